// File: rtl/uart_prog_loader.sv
// uart_prog_loader: frames a UART byte stream as length header, payload words and checksum,
// writes each assembled word to memory and reports done or an error cause.
module uart_prog_loader #(
  parameter int unsigned       WORD_BYTES = 4,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       MAX_WORDS  = 131072,
  parameter bit                BIG_ENDIAN = 1'b1,
  parameter int unsigned       TIMEOUT    = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    restart,
  input  logic                    mem_ready,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WORD_BYTES*8-1:0] mem_wdata,
  output logic [31:0]             words_loaded,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [2:0]              err_code
);
  localparam int unsigned       W        = WORD_BYTES * 8;
  localparam logic [2:0]        LastByte = 3'(WORD_BYTES - 1);
  localparam logic [31:0]       TmoLast  = 32'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(WORD_BYTES);

  localparam logic [2:0] ErrLen  = 3'd1;
  localparam logic [2:0] ErrTmo  = 3'd2;
  localparam logic [2:0] ErrOvr  = 3'd3;
  localparam logic [2:0] ErrCsum = 3'd4;

  typedef enum logic [2:0] {StHdr, StData, StCsum, StWait, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       word_idx_q, word_idx_d;
  logic [W-1:0]      asm_q, asm_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [W-1:0]      wdata_q, wdata_d;
  logic [31:0]       loaded_q, loaded_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       tmo_q, tmo_d;
  logic [2:0]        err_code_q, err_code_d;

  logic [31:0]       len_shift;
  logic [W-1:0]      asm_shift;
  logic              tmo_fire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StHdr;
      byte_cnt_q  <= '0;
      len_q       <= '0;
      word_idx_q  <= '0;
      asm_q       <= '0;
      pend_q      <= 1'b0;
      addr_q      <= '0;
      next_addr_q <= '0;
      wdata_q     <= '0;
      loaded_q    <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      asm_q       <= asm_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      wdata_q     <= wdata_d;
      loaded_q    <= loaded_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    asm_d       = asm_q;
    pend_d      = pend_q;
    addr_d      = addr_q;
    next_addr_d = next_addr_q;
    wdata_d     = wdata_q;
    loaded_d    = loaded_q;
    csum_d      = csum_q;
    tmo_d       = tmo_q;
    err_code_d  = err_code_q;
    tmo_fire    = 1'b0;

    len_shift = {len_q[23:0], rx_data};
    if (BIG_ENDIAN) asm_shift = (asm_q << 8) | W'(rx_data);
    else            asm_shift = (asm_q >> 8) | (W'(rx_data) << (W - 8));

    if (pend_q && mem_ready) begin
      pend_d = 1'b0;
      if (loaded_q != '1) loaded_d = loaded_q + 32'd1;
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    if (!busy || rx_valid) begin
      tmo_d = '0;
    end else begin
      tmo_d    = tmo_q + 32'd1;
      tmo_fire = (TIMEOUT != 0) && (tmo_q == TmoLast);
    end

    case (state_q)
      StHdr: begin
        if (rx_valid) begin
          len_d      = len_shift;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd3) begin
            byte_cnt_d  = '0;
            word_idx_d  = '0;
            next_addr_d = BASE_ADDR;
            if (len_shift > MAX_WORDS) begin
              state_d    = StErr;
              err_code_d = ErrLen;
            end else if (len_shift == '0) begin
              state_d = StCsum;
            end else begin
              state_d = StData;
            end
          end
        end else if (tmo_fire) begin
          state_d    = StErr;
          err_code_d = ErrTmo;
        end
      end
      StData: begin
        if (rx_valid) begin
          csum_d     = csum_q + rx_data;
          asm_d      = asm_shift;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == LastByte) begin
            byte_cnt_d = '0;
            // A write retiring this very cycle frees the slot for the new word.
            if (pend_q && !mem_ready) begin
              state_d    = StErr;
              err_code_d = ErrOvr;
              pend_d     = 1'b0;
            end else begin
              pend_d      = 1'b1;
              wdata_d     = asm_shift;
              addr_d      = next_addr_q;
              next_addr_d = next_addr_q + AddrStep;
              word_idx_d  = word_idx_q + 32'd1;
              if (word_idx_q + 32'd1 == len_q) state_d = StCsum;
            end
          end
        end else if (tmo_fire) begin
          state_d    = StErr;
          err_code_d = ErrTmo;
          pend_d     = 1'b0;
        end
      end
      StCsum: begin
        if (rx_valid) begin
          if (rx_data != csum_q) begin
            state_d    = StErr;
            err_code_d = ErrCsum;
            pend_d     = 1'b0;
          end else if (pend_q && !mem_ready) begin
            state_d = StWait;
          end else begin
            state_d = StDone;
          end
        end else if (tmo_fire) begin
          state_d    = StErr;
          err_code_d = ErrTmo;
          pend_d     = 1'b0;
        end
      end
      StWait: begin
        if (!pend_q || mem_ready) begin
          state_d = StDone;
        end else if (tmo_fire) begin
          state_d    = StErr;
          err_code_d = ErrTmo;
          pend_d     = 1'b0;
        end
      end
      StDone, StErr: begin
        if (restart) begin
          state_d    = StHdr;
          byte_cnt_d = '0;
          loaded_d   = '0;
          csum_d     = '0;
          err_code_d = '0;
        end
      end
      default: state_d = StHdr;
    endcase
  end

  // Reset drops the write request combinationally so a partial frame never lands.
  assign mem_we       = pend_q & rst;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign words_loaded = loaded_q;
  assign busy         = (state_q == StHdr && byte_cnt_q != 3'd0) || (state_q == StData) ||
                        (state_q == StCsum) || (state_q == StWait);
  assign done         = (state_q == StDone);
  assign error        = (state_q == StErr);
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: a big-endian instance at 0x0 and a little-endian one at 0x100
// share one byte stream and are checked against a frame-level model.
module tb_uart_prog_loader;
  localparam int unsigned MaxWords = 131072;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       rx_valid  = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       restart   = 1'b0;
  logic       mem_ready = 1'b1;
  logic [1:0] we, busy, done_s, error_s;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] wl    [2];
  logic [2:0]  ec    [2];

  int vectors     = 0;
  int miscompares = 0;
  int ready_mode  = 1;  // 0 stall, 1 always ready, 2 random with bounded stall
  int stall       = 0;

  logic [31:0] cap_a0[$], cap_d0[$], cap_a1[$], cap_d1[$];
  logic [7:0]  pay[$];

  always #5 clk = ~clk;

  uart_prog_loader #(.WORD_BYTES(4), .ADDR_W(32), .BASE_ADDR(32'h0), .MAX_WORDS(MaxWords),
                     .BIG_ENDIAN(1'b1), .TIMEOUT(50)) dut_be (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .restart(restart),
    .mem_ready(mem_ready), .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
    .words_loaded(wl[0]), .busy(busy[0]), .done(done_s[0]), .error(error_s[0]),
    .err_code(ec[0])
  );

  uart_prog_loader #(.WORD_BYTES(4), .ADDR_W(32), .BASE_ADDR(32'h100), .MAX_WORDS(MaxWords),
                     .BIG_ENDIAN(1'b0), .TIMEOUT(50)) dut_le (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .restart(restart),
    .mem_ready(mem_ready), .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
    .words_loaded(wl[1]), .busy(busy[1]), .done(done_s[1]), .error(error_s[1]),
    .err_code(ec[1])
  );

  // Drive mem_ready for the coming edge, then record writes that edge will accept.
  always @(negedge clk) begin
    if (ready_mode == 0) mem_ready = 1'b0;
    else if (ready_mode == 1) mem_ready = 1'b1;
    else if (stall >= 2) begin
      mem_ready = 1'b1;
      stall = 0;
    end else begin
      mem_ready = 1'($urandom_range(1, 0));
      stall = mem_ready ? 0 : stall + 1;
    end
    if (we[0] && mem_ready) begin cap_a0.push_back(addr[0]); cap_d0.push_back(wdata[0]); end
    if (we[1] && mem_ready) begin cap_a1.push_back(addr[1]); cap_d1.push_back(wdata[1]); end
  end

  function automatic int cap_n(input int d);
    return (d == 0) ? cap_a0.size() : cap_a1.size();
  endfunction
  function automatic logic [31:0] cap_addr(input int d, input int k);
    return (d == 0) ? cap_a0[k] : cap_a1[k];
  endfunction
  function automatic logic [31:0] cap_data(input int d, input int k);
    return (d == 0) ? cap_d0[k] : cap_d1[k];
  endfunction

  function automatic logic [31:0] exp_addr(input int d, input int k);
    return ((d == 0) ? 32'h0 : 32'h100) + 32'(4 * k);
  endfunction
  // Instance 0 puts the first byte of a word in the MSB, instance 1 in the LSB.
  function automatic logic [31:0] exp_data(input int d, input int k);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < 4; j++) v = v | (32'(pay[4*k+j]) << ((d == 0) ? 8 * (3 - j) : 8 * j));
    return v;
  endfunction
  function automatic logic [7:0] pay_sum();
    logic [7:0] s;
    s = '0;
    foreach (pay[i]) s = s + pay[i];
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] len, input logic [7:0] cs, input int max_gap,
                            input int cs_gap);
    for (int i = 3; i >= 0; i--) send_byte(len[8*i +: 8], $urandom_range(max_gap, 0));
    foreach (pay[i]) send_byte(pay[i], $urandom_range(max_gap, 0));
    repeat (cs_gap) @(negedge clk);
    send_byte(cs, 0);
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((done_s | error_s) == 2'b11 && we == 2'b00) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    cap_a0.delete(); cap_d0.delete(); cap_a1.delete(); cap_d1.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({we[d], busy[d], done_s[d], error_s[d], ec[d], wl[d], addr[d], wdata[d]} !== '0) begin
        miscompares++;
        $display("FAIL reset dut%0d: got we=%b busy=%b done=%b err=%b code=%0d wl=%0d a=%h d=%h, want all 0",
                 d, we[d], busy[d], done_s[d], error_s[d], ec[d], wl[d], addr[d], wdata[d]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] ed [4] = '{32'h11223344, 32'h55667788, 32'h44332211, 32'h88776655};
    logic [31:0] ea [4] = '{32'h0, 32'h4, 32'h100, 32'h104};
    bit ok;
    pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(32'd2, 8'h64, 0, 0);
    wait_end(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL directed_end: got no end state, want done"); end
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (cap_n(d) != 2) begin
        miscompares++;
        $display("FAIL directed_count dut%0d: got %0d writes, want 2", d, cap_n(d));
      end
      for (int k = 0; k < 2 && k < cap_n(d); k++) begin
        vectors++;
        if (cap_addr(d, k) !== ea[2*d+k] || cap_data(d, k) !== ed[2*d+k]) begin
          miscompares++;
          $display("FAIL directed_write dut%0d #%0d: got %h@%h, want %h@%h", d, k,
                   cap_data(d, k), cap_addr(d, k), ed[2*d+k], ea[2*d+k]);
        end
      end
      vectors++;
      if (wl[d] !== 32'd2 || done_s[d] !== 1'b1 || error_s[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL directed_status dut%0d: got wl=%0d done=%b err=%b, want 2 1 0",
                 d, wl[d], done_s[d], error_s[d]);
      end
    end
    do_restart();
  endtask

  task automatic test_bad_csum();
    bit ok;
    pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(32'd2, 8'h65, 0, 0);
    wait_end(ok);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (error_s[d] !== 1'b1 || ec[d] !== 3'd4 || done_s[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL bad_csum dut%0d: got err=%b code=%0d done=%b, want 1 4 0",
                 d, error_s[d], ec[d], done_s[d]);
      end
    end
    do_restart();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({error_s[d], done_s[d], ec[d], wl[d]} !== '0) begin
        miscompares++;
        $display("FAIL restart_clear dut%0d: got err=%b done=%b code=%0d wl=%0d, want all 0",
                 d, error_s[d], done_s[d], ec[d], wl[d]);
      end
    end
    send_frame(32'd2, 8'h64, 0, 0);
    wait_end(ok);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (done_s[d] !== 1'b1 || wl[d] !== 32'd2) begin
        miscompares++;
        $display("FAIL resend dut%0d: got done=%b wl=%0d, want 1 2", d, done_s[d], wl[d]);
      end
    end
    do_restart();
  endtask

  task automatic test_max_len();
    send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (error_s[d] !== 1'b1 || ec[d] !== 3'd1 || we[d] !== 1'b0 || cap_n(d) != 0) begin
        miscompares++;
        $display("FAIL max_len dut%0d: got err=%b code=%0d we=%b writes=%0d, want 1 1 0 0",
                 d, error_s[d], ec[d], we[d], cap_n(d));
      end
    end
    do_restart();
    send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    vectors++;
    if (busy !== 2'b11 || error_s !== 2'b00) begin
      miscompares++;
      $display("FAIL max_len_edge: got busy=%b err=%b, want 11 00", busy, error_s);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_overrun();
    logic [31:0] ea [2] = '{32'h0, 32'h100};
    logic [31:0] ed [2] = '{32'h11223344, 32'h44332211};
    logic [7:0]  rest [3] = '{8'h55, 8'h66, 8'h77};
    ready_mode = 0;
    repeat (2) @(negedge clk);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (we[d] !== 1'b1 || addr[d] !== ea[d] || wdata[d] !== ed[d]) begin
          miscompares++;
          $display("FAIL overrun_hold dut%0d step%0d: got we=%b %h@%h, want 1 %h@%h",
                   d, i, we[d], wdata[d], addr[d], ed[d], ea[d]);
        end
      end
      if (i < 3) send_byte(rest[i], 0);
    end
    send_byte(8'h88, 0);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (error_s[d] !== 1'b1 || ec[d] !== 3'd3 || we[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL overrun dut%0d: got err=%b code=%0d we=%b, want 1 3 0",
                 d, error_s[d], ec[d], we[d]);
      end
    end
    ready_mode = 1;
    do_restart();
  endtask

  task automatic test_timeout();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    repeat (49) @(negedge clk);
    vectors++;
    if (error_s !== 2'b00) begin
      miscompares++;
      $display("FAIL timeout_early: got err=%b after 49 cycles, want 00", error_s);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (error_s[d] !== 1'b1 || ec[d] !== 3'd2) begin
        miscompares++;
        $display("FAIL timeout dut%0d: got err=%b code=%0d after 50 cycles, want 1 2",
                 d, error_s[d], ec[d]);
      end
    end
    do_restart();
  endtask

  task automatic test_reset_mid();
    ready_mode = 0;
    repeat (2) @(negedge clk);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    vectors++;
    if (we !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got we=%b, want 11", we);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (we !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_mid_we: got we=%b while rst low, want 00", we);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({we[d], busy[d], done_s[d], error_s[d], ec[d], wl[d], addr[d], wdata[d]} !== '0 ||
          cap_n(d) != 0) begin
        miscompares++;
        $display("FAIL reset_mid dut%0d: got we=%b busy=%b wl=%0d a=%h d=%h writes=%0d, want 0",
                 d, we[d], busy[d], wl[d], addr[d], wdata[d], cap_n(d));
      end
    end
    rst = 1'b1;
    ready_mode = 1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int n;
      bit big, bad, ok, exp_done;
      logic [7:0]  cs;
      logic [31:0] len;
      logic [2:0]  exp_code;
      ready_mode = 2;
      big = ($urandom_range(7, 0) == 0);
      bad = ($urandom_range(3, 0) == 0);
      pay.delete();
      if (big) begin
        len = 32'(MaxWords) + 32'd1 + 32'($urandom_range(1000, 0));
        n = 0;
      end else begin
        n = $urandom_range(5, 0);
        len = 32'(n);
        for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom));
      end
      cs = pay_sum();
      if (bad) cs = cs ^ 8'($urandom_range(255, 1));
      exp_code = big ? 3'd1 : (bad ? 3'd4 : 3'd0);
      exp_done = !big && !bad;
      send_frame(len, cs, 3, bad ? 4 : 0);
      wait_end(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL rand_end it%0d: got no end state", it); end
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (done_s[d] !== exp_done || error_s[d] !== !exp_done || ec[d] !== exp_code ||
            wl[d] !== 32'(n) || cap_n(d) != n) begin
          miscompares++;
          $display("FAIL rand_status it%0d dut%0d: got done=%b err=%b code=%0d wl=%0d writes=%0d, want %b %b %0d %0d %0d",
                   it, d, done_s[d], error_s[d], ec[d], wl[d], cap_n(d), exp_done, !exp_done,
                   exp_code, n, n);
        end
        for (int k = 0; k < n && k < cap_n(d); k++) begin
          vectors++;
          if (cap_addr(d, k) !== exp_addr(d, k) || cap_data(d, k) !== exp_data(d, k)) begin
            miscompares++;
            $display("FAIL rand_write it%0d dut%0d #%0d: got %h@%h, want %h@%h", it, d, k,
                     cap_data(d, k), cap_addr(d, k), exp_data(d, k), exp_addr(d, k));
          end
        end
      end
      ready_mode = 1;
      do_restart();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bad_csum();
    test_max_len();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
